// File: rtl/cpu_axi_pkg.sv
// ============================================================================
// Module   : cpu_axi_pkg
// Purpose  : Shared AXI read-path types and constants for the CPU AXI master.
// Revision : 1.0
// ============================================================================
`default_nettype none

package cpu_axi_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2
    } arb_state_t;

    localparam logic [2:0] SIZE_4B     = 3'b010;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] LOCK_NORMAL = 2'b00;
    localparam logic [3:0] CACHE_NONE  = 4'b0000;
    localparam logic [2:0] PROT_NONE   = 3'b000;

    localparam logic [3:0] ICACHE_ID   = 4'b0001;
    localparam logic [3:0] DCACHE_ID   = 4'b0010;

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================================
// Module   : rr_arb2
// Purpose  : Two-requester round-robin arbiter with a last-served pointer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       upd,
    input  logic       upd_idx,
    output logic       any_req,
    output logic       win
);

    logic r_last;

    // Pointer starts at 1 so requester 0 wins the first tie after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (upd) begin
            r_last <= upd_idx;
        end
    end

    assign any_req = |req;
    assign win     = (req == 2'b11) ? ~r_last : req[1];

endmodule

`default_nettype wire

// File: rtl/axi_rd_arbiter.sv
// ============================================================================
// Module   : axi_rd_arbiter
// Purpose  : Merges ICache (port 0) and DCache (port 1) AXI3 read channels onto
//            one master, one outstanding burst, grant locked AR through last R.
// Revision : 1.0
// ============================================================================
`default_nettype none

module axi_rd_arbiter
    import cpu_axi_pkg::*;
#(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ID_W-1:0]   s0_arid,
    input  logic [ADDR_W-1:0] s0_araddr,
    input  logic [LEN_W-1:0]  s0_arlen,
    input  logic [2:0]        s0_arsize,
    input  logic [1:0]        s0_arburst,
    input  logic              s0_arvalid,
    output logic              s0_arready,
    output logic [ID_W-1:0]   s0_rid,
    output logic [DATA_W-1:0] s0_rdata,
    output logic [1:0]        s0_rresp,
    output logic              s0_rlast,
    output logic              s0_rvalid,
    input  logic              s0_rready,
    input  logic [ID_W-1:0]   s1_arid,
    input  logic [ADDR_W-1:0] s1_araddr,
    input  logic [LEN_W-1:0]  s1_arlen,
    input  logic [2:0]        s1_arsize,
    input  logic [1:0]        s1_arburst,
    input  logic              s1_arvalid,
    output logic              s1_arready,
    output logic [ID_W-1:0]   s1_rid,
    output logic [DATA_W-1:0] s1_rdata,
    output logic [1:0]        s1_rresp,
    output logic              s1_rlast,
    output logic              s1_rvalid,
    input  logic              s1_rready,
    output logic [ID_W-1:0]   m_arid,
    output logic [ADDR_W-1:0] m_araddr,
    output logic [LEN_W-1:0]  m_arlen,
    output logic [2:0]        m_arsize,
    output logic [1:0]        m_arburst,
    output logic [1:0]        m_arlock,
    output logic [3:0]        m_arcache,
    output logic [2:0]        m_arprot,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic [ID_W-1:0]   m_rid,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rlast,
    input  logic              m_rvalid,
    output logic              m_rready,
    output logic              grant,
    output logic              busy,
    output logic              len_err
);

    localparam logic [LEN_W:0] c_beat_one = {{LEN_W{1'b0}}, 1'b1};

    arb_state_t     r_state;
    arb_state_t     w_state_nxt;
    logic           r_grant;
    logic [LEN_W:0] r_beat;
    logic           r_len_err;
    logic           w_any_req;
    logic           w_win;
    logic           w_ar_hs;
    logic           w_r_hs;
    logic           w_capture;

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .rst     (rst),
        .req     ({s1_arvalid, s0_arvalid}),
        .upd     (w_ar_hs),
        .upd_idx (r_grant),
        .any_req (w_any_req),
        .win     (w_win)
    );

    assign w_capture = (r_state == ST_IDLE) && w_any_req;
    assign w_ar_hs   = (r_state == ST_AR) && m_arvalid && m_arready;
    assign w_r_hs    = m_rvalid && m_rready;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_any_req)          w_state_nxt = ST_AR;
            ST_AR:   if (w_ar_hs)            w_state_nxt = ST_R;
            ST_R:    if (w_r_hs && m_rlast)  w_state_nxt = ST_IDLE;
            default:                         w_state_nxt = ST_IDLE;
        endcase
    end

    // Routing follows grant only; rid is forwarded untouched.
    always_comb begin
        s0_arready = 1'b0;
        s1_arready = 1'b0;
        m_rready   = 1'b0;
        s0_rid     = '0;
        s0_rdata   = '0;
        s0_rresp   = '0;
        s0_rlast   = 1'b0;
        s0_rvalid  = 1'b0;
        s1_rid     = '0;
        s1_rdata   = '0;
        s1_rresp   = '0;
        s1_rlast   = 1'b0;
        s1_rvalid  = 1'b0;
        if (r_state == ST_AR) begin
            s0_arready = ~r_grant & m_arready;
            s1_arready =  r_grant & m_arready;
        end
        if (r_state == ST_R) begin
            if (r_grant) begin
                m_rready  = s1_rready;
                s1_rid    = m_rid;
                s1_rdata  = m_rdata;
                s1_rresp  = m_rresp;
                s1_rlast  = m_rlast;
                s1_rvalid = m_rvalid;
            end else begin
                m_rready  = s0_rready;
                s0_rid    = m_rid;
                s0_rdata  = m_rdata;
                s0_rresp  = m_rresp;
                s0_rlast  = m_rlast;
                s0_rvalid = m_rvalid;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_grant   <= 1'b0;
            r_beat    <= '0;
            r_len_err <= 1'b0;
            m_arid    <= '0;
            m_araddr  <= '0;
            m_arlen   <= '0;
            m_arsize  <= '0;
            m_arburst <= '0;
            m_arvalid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_capture) begin
                r_grant   <= w_win;
                r_beat    <= '0;
                m_arvalid <= 1'b1;
                m_arid    <= w_win ? s1_arid    : s0_arid;
                m_araddr  <= w_win ? s1_araddr  : s0_araddr;
                m_arlen   <= w_win ? s1_arlen   : s0_arlen;
                m_arsize  <= w_win ? s1_arsize  : s0_arsize;
                m_arburst <= w_win ? s1_arburst : s0_arburst;
            end
            if (w_ar_hs) begin
                m_arvalid <= 1'b0;
            end
            // Flags both an early rlast and a missing rlast at beat arlen.
            if (w_r_hs) begin
                r_beat <= r_beat + c_beat_one;
                if (m_rlast != (r_beat == {1'b0, m_arlen})) begin
                    r_len_err <= 1'b1;
                end
            end
        end
    end

    assign m_arlock  = LOCK_NORMAL;
    assign m_arcache = CACHE_NONE;
    assign m_arprot  = PROT_NONE;
    assign grant     = r_grant;
    assign busy      = (r_state != ST_IDLE);
    assign len_err   = r_len_err;

endmodule

`default_nettype wire

// File: tb/tb_axi_rd_arbiter.sv
// ============================================================================
// Module   : tb_axi_rd_arbiter
// Purpose  : Randomized scoreboard bench for axi_rd_arbiter.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_axi_rd_arbiter;
    import cpu_axi_pkg::*;

    localparam int ID_W   = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [ID_W-1:0]   s0_arid, s1_arid, s0_rid, s1_rid, m_arid, m_rid;
    logic [ADDR_W-1:0] s0_araddr, s1_araddr, m_araddr;
    logic [LEN_W-1:0]  s0_arlen, s1_arlen, m_arlen;
    logic [2:0]        s0_arsize, s1_arsize, m_arsize, m_arprot;
    logic [1:0]        s0_arburst, s1_arburst, m_arburst, m_arlock;
    logic [3:0]        m_arcache;
    logic              s0_arvalid, s1_arvalid, s0_arready, s1_arready;
    logic [DATA_W-1:0] s0_rdata, s1_rdata, m_rdata;
    logic [1:0]        s0_rresp, s1_rresp, m_rresp;
    logic              s0_rlast, s1_rlast, s0_rvalid, s1_rvalid, s0_rready, s1_rready;
    logic              m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;
    logic              grant, busy, len_err;

    axi_rd_arbiter #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst),
        .s0_arid(s0_arid), .s0_araddr(s0_araddr), .s0_arlen(s0_arlen), .s0_arsize(s0_arsize),
        .s0_arburst(s0_arburst), .s0_arvalid(s0_arvalid), .s0_arready(s0_arready),
        .s0_rid(s0_rid), .s0_rdata(s0_rdata), .s0_rresp(s0_rresp), .s0_rlast(s0_rlast),
        .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
        .s1_arid(s1_arid), .s1_araddr(s1_araddr), .s1_arlen(s1_arlen), .s1_arsize(s1_arsize),
        .s1_arburst(s1_arburst), .s1_arvalid(s1_arvalid), .s1_arready(s1_arready),
        .s1_rid(s1_rid), .s1_rdata(s1_rdata), .s1_rresp(s1_rresp), .s1_rlast(s1_rlast),
        .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_arlock(m_arlock), .m_arcache(m_arcache), .m_arprot(m_arprot),
        .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_rvalid(m_rvalid), .m_rready(m_rready),
        .grant(grant), .busy(busy), .len_err(len_err)
    );

    typedef struct { int owner; logic [3:0] id; logic [3:0] len; } burst_t;
    typedef struct { int owner; logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; } beat_t;

    burst_t      bq[$];
    beat_t       exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [3:0]  req_id[2];
    logic [31:0] req_addr[2];
    logic [3:0]  req_len[2];
    int          done_cnt[2];
    int          beats_total = 0;
    int          err_mode = 0;
    bit          model_len_err = 0;
    int          model_last = 1;
    int          cur_owner = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Cache-side requester: holds AR until accepted, then waits for its own burst.
    task automatic do_req(input int p, input logic [31:0] addr, input logic [3:0] len);
        int t;
        int d0;
        logic [3:0] id;
        id = 4'($urandom_range(0, 15));
        @(posedge clk); #1;
        req_id[p] = id; req_addr[p] = addr; req_len[p] = len;
        d0 = done_cnt[p];
        if (p == 0) begin
            s0_arid = id; s0_araddr = addr; s0_arlen = len;
            s0_arsize = SIZE_4B; s0_arburst = BURST_INCR; s0_arvalid = 1'b1;
        end else begin
            s1_arid = id; s1_araddr = addr; s1_arlen = len;
            s1_arsize = SIZE_4B; s1_arburst = BURST_INCR; s1_arvalid = 1'b1;
        end
        t = 0;
        forever begin
            @(negedge clk);
            if (rst) break;
            if ((p == 0) ? s0_arready : s1_arready) break;
            if (++t > 3000) begin fail_now("ar_wait_timeout"); break; end
        end
        @(posedge clk); #1;
        if (p == 0) s0_arvalid = 1'b0; else s1_arvalid = 1'b0;
        t = 0;
        while (done_cnt[p] == d0 && !rst) begin
            @(negedge clk);
            if (++t > 3000) begin fail_now("burst_timeout"); break; end
        end
    endtask

    initial begin
        m_arready = 1'b0;
        forever begin @(posedge clk); #1; m_arready = ($urandom_range(0, 2) == 0); end
    end

    initial begin
        s0_rready = 1'b0; s1_rready = 1'b0;
        forever begin
            @(posedge clk); #1;
            s0_rready = ($urandom_range(0, 3) != 0);
            s1_rready = ($urandom_range(0, 3) != 0);
        end
    end

    // AR monitor and reference arbitration model.
    initial begin : ar_mon
        logic [1:0] prev_req;
        bit prev_mv;
        bit prev_stall;
        prev_req = 2'b00; prev_mv = 0; prev_stall = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_req = 2'b00; prev_mv = 0; prev_stall = 0;
                model_last = 1; model_len_err = 0;
                continue;
            end
            if (m_arvalid && !prev_mv) begin
                if (prev_req == 2'b00) fail_now("ar_without_request");
                cur_owner = (prev_req == 2'b11) ? ((model_last == 0) ? 1 : 0) : (prev_req[1] ? 1 : 0);
                chk("grant", grant, cur_owner);
            end
            if (prev_stall) chk("arvalid_hold", m_arvalid, 1'b1);
            if (m_arvalid) begin
                chk("ar_fields", {m_arid, m_araddr, m_arlen, m_arsize, m_arburst},
                    {req_id[cur_owner], req_addr[cur_owner], req_len[cur_owner], SIZE_4B, BURST_INCR});
                chk("ar_ready_route", {s1_arready, s0_arready},
                    (cur_owner == 1) ? {m_arready, 1'b0} : {1'b0, m_arready});
                if (m_arready) begin
                    model_last = cur_owner;
                    bq.push_back('{cur_owner, req_id[cur_owner], req_len[cur_owner]});
                end
            end else begin
                chk("ar_ready_idle", {s1_arready, s0_arready}, 2'b00);
            end
            prev_stall = m_arvalid && !m_arready;
            prev_mv    = m_arvalid;
            prev_req   = {s1_arvalid, s0_arvalid};
        end
    end

    // Interconnect R responder: issues beats and pushes the expected routed beat.
    initial begin : r_resp
        burst_t b;
        int nb;
        int t;
        bit abort;
        logic [31:0] d;
        logic [1:0] rs;
        m_rvalid = 1'b0; m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin bq.delete(); continue; end
            if (bq.size() == 0) continue;
            b = bq.pop_front();
            nb = int'(b.len) + 1;
            if (err_mode == 1 && b.len > 0) nb = int'(b.len);
            else if (err_mode == 2) nb = int'(b.len) + 2;
            if (nb != int'(b.len) + 1) model_len_err = 1;
            abort = 0;
            for (int i = 0; i < nb && !abort; i++) begin
                if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
                if (rst) begin abort = 1; break; end
                d = $urandom; rs = 2'($urandom_range(0, 3));
                m_rvalid = 1'b1; m_rid = b.id; m_rdata = d; m_rresp = rs; m_rlast = (i == nb - 1);
                exp_q.push_back('{b.owner, b.id, d, rs, (i == nb - 1)});
                t = 0;
                forever begin
                    @(negedge clk);
                    if (rst) begin abort = 1; break; end
                    if (m_rready) break;
                    if (++t > 500) begin fail_now("r_accept_timeout"); abort = 1; break; end
                end
                @(posedge clk); #1;
                m_rvalid = 1'b0; m_rlast = 1'b0;
            end
        end
    end

    // R monitor: pops the scoreboard whenever a slave accepts a beat.
    initial begin : r_mon
        beat_t e;
        logic [3:0] rid;
        logic [31:0] rdata;
        logic [1:0] rresp;
        logic rlast, other_v, hs;
        forever begin
            @(negedge clk);
            if (rst) continue;
            for (int k = 0; k < 2; k++) begin
                hs      = (k == 0) ? (s0_rvalid && s0_rready) : (s1_rvalid && s1_rready);
                rid     = (k == 0) ? s0_rid   : s1_rid;
                rdata   = (k == 0) ? s0_rdata : s1_rdata;
                rresp   = (k == 0) ? s0_rresp : s1_rresp;
                rlast   = (k == 0) ? s0_rlast : s1_rlast;
                other_v = (k == 0) ? s1_rvalid : s0_rvalid;
                if (hs) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL r_unexpected: port %0d got beat, required none", k);
                    end else begin
                        e = exp_q.pop_front();
                        chk("r_port", k, e.owner);
                        chk("r_beat", {rid, rdata, rresp, rlast, other_v},
                            {e.id, e.data, e.resp, e.last, 1'b0});
                        beats_total++;
                        if (e.last) done_cnt[e.owner]++;
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int b0;
        int t;
        done_cnt[0] = 0; done_cnt[1] = 0;
        s0_arid = '0; s0_araddr = '0; s0_arlen = '0; s0_arsize = '0; s0_arburst = '0; s0_arvalid = 1'b0;
        s1_arid = '0; s1_araddr = '0; s1_arlen = '0; s1_arsize = '0; s1_arburst = '0; s1_arvalid = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_m_ar", {m_arvalid, m_arid, m_araddr, m_arlen, m_arsize, m_arburst}, '0);
        chk("rst_grant_busy_err", {grant, busy, len_err}, 3'b000);
        chk("rst_arready", {s0_arready, s1_arready}, 2'b00);
        chk("rst_rvalid_rready", {s0_rvalid, s1_rvalid, m_rready}, 3'b000);
        chk("const_fields", {m_arlock, m_arcache, m_arprot}, {LOCK_NORMAL, CACHE_NONE, PROT_NONE});
        @(posedge clk); #1;
        rst = 1'b0;

        // Simultaneous first requests, then randomized traffic from both caches.
        fork
            begin
                do_req(0, 32'h1FC0_0000, 4'hF);
                for (int n = 0; n < 12; n++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    do_req(0, $urandom & 32'hFFFF_FFFC, 4'($urandom_range(0, 15)));
                end
            end
            begin
                do_req(1, 32'h0000_1000, 4'd3);
                for (int n = 0; n < 12; n++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    do_req(1, $urandom & 32'hFFFF_FFFC, 4'($urandom_range(0, 15)));
                end
            end
        join
        repeat (3) @(negedge clk);
        chk("len_err_clean", len_err, model_len_err);
        chk("idle_after_traffic", busy, 1'b0);

        // Missing rlast at beat arlen: overflow keeps the burst open until rlast.
        err_mode = 2;
        do_req(1, 32'h0000_2000, 4'd2);
        err_mode = 0;
        repeat (2) @(negedge clk);
        chk("len_err_overflow", len_err, model_len_err);

        // Reset in the middle of a long ICache burst.
        b0 = beats_total;
        fork
            do_req(0, 32'h1FC0_0000, 4'hF);
            begin
                t = 0;
                while (beats_total < b0 + 5 && t < 2000) begin @(negedge clk); t++; end
                if (t >= 2000) fail_now("rst_trigger_timeout");
                @(posedge clk); #1;
                rst = 1'b1;
                #1;
                chk("rst_mid_m_rready", m_rready, 1'b0);
                chk("rst_mid_state", {busy, m_arvalid, s0_rvalid, len_err}, 4'b0000);
                repeat (2) @(posedge clk); #1;
                rst = 1'b0;
            end
        join
        repeat (2) @(posedge clk);
        exp_q.delete();

        // After reset the pointer is back to ICache-first for a tie.
        fork
            do_req(0, 32'h1FC0_0040, 4'd1);
            do_req(1, 32'h0000_3000, 4'd2);
        join
        repeat (2) @(negedge clk);
        chk("len_err_after_rst", len_err, model_len_err);

        // Early rlast: sticky error, next burst still served normally.
        err_mode = 1;
        do_req(0, 32'h0000_4000, 4'd3);
        err_mode = 0;
        repeat (2) @(negedge clk);
        chk("len_err_early", len_err, model_len_err);
        do_req(1, 32'h0000_5000, 4'd3);
        repeat (2) @(negedge clk);
        chk("len_err_sticky", len_err, model_len_err);
        chk("final_idle", busy, 1'b0);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
